// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: state encoding, byte width and clog2 helper shared by the UART TX arbiter
package uart_arb_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, HOLD} arb_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin pick of the first valid requester after ptr
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          hit
);
  always_comb begin
    grant = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!hit && valid[(int'(ptr) + i) % N]) begin
        hit = 1'b1;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx = PW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte streams with frame locking
// UART_ARB_LOCK_TIMEOUT_EN enables releasing a stalled lock after LOCK_TIMEOUT idle cycles
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_FRAME    = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                    i_Clock,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_Req_Valid,
  input  logic [BYTE_W*N_REQ-1:0] i_Req_Byte,
  input  logic [N_REQ-1:0]        i_Req_Last,
  output logic [N_REQ-1:0]        o_Req_Ack,
  output logic [N_REQ-1:0]        o_Grant,
  output logic                    o_Tx_DV,
  output logic [BYTE_W-1:0]       o_Tx_Byte,
  input  logic                    i_Tx_Active,
  input  logic                    i_Tx_Done,
  output logic                    o_Busy,
  output logic                    o_Lock_Err
);
  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(MAX_FRAME + 1);
  arb_state_t state;
  logic [PW-1:0] ptr, owner, pick_idx;
  logic [N_REQ-1:0] pick_grant;
  logic pick_hit, last_q, done_q, tx_ready, done_rise, frame_end;
  logic [CW-1:0] frame_cnt;
  uart_rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
    .valid(i_Req_Valid),
    .ptr(ptr),
    .grant(pick_grant),
    .idx(pick_idx),
    .hit(pick_hit)
  );
  // Done stays high through uart_tx cleanup, so ready needs both status lines low
  assign tx_ready = !i_Tx_Active && !i_Tx_Done;
  assign done_rise = i_Tx_Done && !done_q;
  assign frame_end = last_q || frame_cnt == CW'(MAX_FRAME);
  assign o_Busy = state != IDLE;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
  localparam int TW = clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic stall_out;
  assign stall_out = idle_cnt == TW'(LOCK_TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^LOCK_TIMEOUT;
  assign o_Lock_Err = 1'b0;
`endif
  always_ff @(posedge i_Clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      ptr <= PW'(N_REQ - 1);
      owner <= '0;
      o_Grant <= '0;
      o_Req_Ack <= '0;
      o_Tx_DV <= 1'b0;
      o_Tx_Byte <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      frame_cnt <= '0;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
      idle_cnt <= '0;
      o_Lock_Err <= 1'b0;
`endif
    end else begin
      done_q <= i_Tx_Done;
      o_Tx_DV <= 1'b0;
      o_Req_Ack <= '0;
      case (state)
        IDLE: if (pick_hit && tx_ready) begin
          state <= LAUNCH;
          owner <= pick_idx;
          o_Grant <= pick_grant;
          o_Tx_Byte <= i_Req_Byte[BYTE_W*pick_idx +: BYTE_W];
          last_q <= i_Req_Last[pick_idx];
        end
        LAUNCH: begin
          state <= WAIT_DONE;
          o_Tx_DV <= 1'b1;
          o_Req_Ack <= o_Grant;
          frame_cnt <= frame_cnt == CW'(MAX_FRAME) ? frame_cnt : frame_cnt + 1'b1;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
          idle_cnt <= '0;
`endif
        end
        WAIT_DONE: if (done_rise) begin
          if (frame_end) begin
            state <= IDLE;
            ptr <= owner;
            frame_cnt <= '0;
            o_Grant <= '0;
          end else state <= HOLD;
        end
        HOLD: if (i_Req_Valid[owner] && tx_ready) begin
          state <= LAUNCH;
          o_Tx_Byte <= i_Req_Byte[BYTE_W*owner +: BYTE_W];
          last_q <= i_Req_Last[owner];
        end
`ifdef UART_ARB_LOCK_TIMEOUT_EN
        else if (!i_Req_Valid[owner]) begin
          if (stall_out) begin
            state <= IDLE;
            ptr <= owner;
            frame_cnt <= '0;
            o_Grant <= '0;
            idle_cnt <= '0;
            o_Lock_Err <= 1'b1;
          end else idle_cnt <= idle_cnt + 1'b1;
        end
`endif
        default: begin
          state <= IDLE;
          o_Grant <= '0;
          frame_cnt <= '0;
        end
      endcase
    end
  end
endmodule
